// File: rtl/carbon_pkg.sv
// Shared definitions for the carbon core instruction side.
// Contents:
//   CARBON_AW / CARBON_DEPTH / CARBON_IW : address width, word count, instruction width
//   OP_* / C_*                           : opcode and constant field positions
//   NOP_INST                             : all-zero instruction, executed as a NOP
//   ld_state_e                           : program loader state encoding
//   make_inst()                          : packs opcode and constant into one word
package carbon_pkg;

    localparam int CARBON_AW    = 8;
    localparam int CARBON_DEPTH = 1 << CARBON_AW;
    localparam int CARBON_IW    = 14;

    // Instruction layout: OP = [13:8], C = [7:0]
    localparam int OP_MSB = 13;
    localparam int OP_LSB = 8;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;
    localparam int C_MSB  = 7;
    localparam int C_LSB  = 0;
    localparam int C_W    = C_MSB - C_LSB + 1;

    localparam logic [CARBON_IW-1:0] NOP_INST = 14'h0000;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_LOAD_LO = 3'd1,
        LD_LOAD_HI = 3'd2,
        LD_RUN     = 3'd3,
        LD_ERR     = 3'd4
    } ld_state_e;

    function automatic logic [CARBON_IW-1:0] make_inst(
        input logic [OP_W-1:0] op,
        input logic [C_W-1:0]  c
    );
        return {op, c};
    endfunction

endpackage

// File: rtl/carbon_imem.sv
// Instruction memory for the carbon core.
// DEPTH x IW array, synchronous write port and asynchronous (zero-latency)
// read port. Contents are not reset, so a program survives a loader reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational)
//   rdata : read data
module carbon_imem
    import carbon_pkg::*;
#(
    parameter int AW    = CARBON_AW,
    parameter int DEPTH = CARBON_DEPTH,
    parameter int IW    = CARBON_IW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/carbon_prog_loader.sv
// Program loader and instruction responder for the carbon core.
// A host streams a program as byte pairs (low byte = constant, then high
// byte with the opcode in [5:0]) while the core is held in reset. After the
// final word the core is released and fetches are answered from memory.
// Ports:
//   clk       : single clock
//   rst       : asynchronous, active-low reset
//   ld_start  : pulse, begins or restarts a load (highest priority)
//   ld_valid  : host byte valid
//   ld_ready  : loader accepts a byte (LOAD_LO / LOAD_HI only)
//   ld_byte   : program byte
//   ld_last   : marks a high byte as the final instruction
//   pc_in     : fetch address from the core
//   inst_out  : instruction at pc_in while running, NOP otherwise
//   core_hold : 1 holds the core in reset
//   ld_err    : sticky load error (bad high byte or overflow)
//   ld_count  : instructions written by the last load
module carbon_prog_loader
    import carbon_pkg::*;
#(
    parameter int AW    = CARBON_AW,
    parameter int DEPTH = CARBON_DEPTH,
    parameter int IW    = CARBON_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    input  logic [AW-1:0] pc_in,
    output logic [IW-1:0] inst_out,
    output logic          core_hold,
    output logic          ld_err,
    output logic [AW:0]   ld_count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ld_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    lo_q, lo_d;
    logic          mem_we;
    logic          xfer;
    logic [IW-1:0] mem_rdata;

    // ready is a pure function of state so the host sees no combinational
    // path from its own valid back to ready
    assign ld_ready  = (state_q == LD_LOAD_LO) || (state_q == LD_LOAD_HI);
    assign xfer      = ld_valid & ld_ready;
    // Holding is state-derived: core_hold drops only once RUN is entered,
    // i.e. one cycle after the final word has been written
    assign core_hold = (state_q != LD_RUN);
    assign inst_out  = (state_q == LD_RUN) ? mem_rdata : NOP_INST;
    assign ld_err    = err_q;
    assign ld_count  = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        lo_d    = lo_q;
        mem_we  = 1'b0;

        // ld_start wins over everything, including a byte offered this cycle
        if (ld_start) begin
            state_d = LD_LOAD_LO;
            addr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LD_LOAD_LO: begin
                    if (xfer) begin
                        lo_d    = ld_byte;
                        state_d = LD_LOAD_HI;
                    end
                end
                LD_LOAD_HI: begin
                    if (xfer) begin
                        if (ld_byte[7:6] != 2'b00) begin
                            state_d = LD_ERR;
                            err_d   = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            cnt_d  = cnt_q + 1'b1;
                            // Address saturates at the top; only a restart
                            // brings it back to zero
                            if (addr_q != LAST_ADDR) begin
                                addr_d = addr_q + 1'b1;
                            end
                            if (ld_last) begin
                                state_d = LD_RUN;
                            end else if (addr_q == LAST_ADDR) begin
                                state_d = LD_ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d = LD_LOAD_LO;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    carbon_imem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (make_inst(ld_byte[5:0], lo_q)),
        .raddr (pc_in),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_carbon_prog_loader.sv
module tb_carbon_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic [7:0]  pc_in;
    logic [13:0] inst_out;
    logic        core_hold;
    logic        ld_err;
    logic [8:0]  ld_count;

    always #5 clk = ~clk;

    carbon_prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .pc_in     (pc_in),
        .inst_out  (inst_out),
        .core_hold (core_hold),
        .ld_err    (ld_err),
        .ld_count  (ld_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the host has pushed and what the core should see
    logic [13:0] m_mem   [256];
    bit          m_known [256];
    bit          m_loading = 1'b0;
    bit          m_want_hi = 1'b0;
    bit          m_running = 1'b0;
    bit          m_erred   = 1'b0;
    int          m_addr    = 0;
    int          m_count   = 0;
    logic [7:0]  m_lo      = 8'h00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_loading = 1'b0;
            m_want_hi = 1'b0;
            m_running = 1'b0;
            m_erred   = 1'b0;
            m_addr    = 0;
            m_count   = 0;
            m_lo      = 8'h00;
        end else if (ld_start) begin
            m_loading = 1'b1;
            m_want_hi = 1'b0;
            m_running = 1'b0;
            m_erred   = 1'b0;
            m_addr    = 0;
            m_count   = 0;
        end else if (m_loading && ld_valid) begin
            if (!m_want_hi) begin
                m_lo      = ld_byte;
                m_want_hi = 1'b1;
            end else if (ld_byte[7:6] != 2'b00) begin
                m_loading = 1'b0;
                m_erred   = 1'b1;
            end else begin
                m_mem[m_addr]   = {ld_byte[5:0], m_lo};
                m_known[m_addr] = 1'b1;
                m_count         = m_count + 1;
                if (ld_last) begin
                    m_loading = 1'b0;
                    m_running = 1'b1;
                end else if (m_addr == 255) begin
                    m_loading = 1'b0;
                    m_erred   = 1'b1;
                end else begin
                    m_addr    = m_addr + 1;
                    m_want_hi = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",  32'(ld_ready),  32'(m_loading));
        chk("hold",   32'(core_hold), 32'(!m_running));
        chk("err",    32'(ld_err),    32'(m_erred));
        chk("count",  32'(ld_count),  32'(m_count));
        if (!m_running)
            chk("inst_nop", 32'(inst_out), 32'h0);
        else if (m_known[pc_in])
            chk("inst_run", 32'(inst_out), 32'(m_mem[pc_in]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        ld_start = 1'b1;
        ld_valid = 1'b0;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input bit last, input int gap);
        int waited;
        ld_valid = 1'b0;
        repeat (gap) tick();
        ld_byte  = b;
        ld_last  = last;
        ld_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!ld_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!ld_ready) chk("ready_timeout", 32'(ld_ready), 32'h1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] lo, input logic [7:0] hi, input bit last, input int gap);
        xfer(lo, 1'b0, gap);
        xfer(hi, last, gap);
    endtask

    logic [13:0] ov [256];
    logic [13:0] tw [3];

    initial begin
        logic [7:0] lo, hi;

        rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_byte = 8'h00; ld_last = 1'b0; pc_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold",  32'(core_hold), 32'h1);
        chk("rst_ready", 32'(ld_ready),  32'h0);
        chk("rst_err",   32'(ld_err),    32'h0);
        chk("rst_count", 32'(ld_count),  32'h0);
        chk("rst_inst",  32'(inst_out),  32'h0);
        rst = 1'b1;
        tick();

        // Single-word load
        do_start();
        chk("start_ready", 32'(ld_ready), 32'h1);
        xfer(8'h05, 1'b0, 0);
        ld_byte = 8'h01; ld_last = 1'b1; ld_valid = 1'b1;
        @(negedge clk);
        chk("hold_on_last", 32'(core_hold), 32'h1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("hold_released", 32'(core_hold), 32'h0);
        chk("one_count",     32'(ld_count),  32'h1);
        chk("one_inst",      32'(inst_out),  32'h0105);

        // Overflow: 256 words without ld_last
        do_start();
        for (int i = 0; i < 256; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, 63));
            ov[i] = {hi[5:0], lo};
            load_word(lo, hi, 1'b0, 0);
        end
        chk("ovf_err",   32'(ld_err),    32'h1);
        chk("ovf_count", 32'(ld_count),  32'h100);
        chk("ovf_hold",  32'(core_hold), 32'h1);
        chk("ovf_ready", 32'(ld_ready),  32'h0);

        // Three words with ld_valid gapped every other cycle
        do_start();
        for (int i = 0; i < 3; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, 63));
            tw[i] = {hi[5:0], lo};
            load_word(lo, hi, (i == 2), 1);
        end
        chk("three_count", 32'(ld_count), 32'h3);
        for (int i = 0; i < 3; i++) begin
            pc_in = 8'(i);
            #1;
            chk("three_inst", 32'(inst_out), 32'(tw[i]));
        end
        pc_in = 8'd3;
        #1;
        chk("old_mem3", 32'(inst_out), 32'(ov[3]));
        pc_in = 8'd0;
        #1;
        chk("no_wrap0", 32'(inst_out), 32'(tw[0]));
        for (int i = 0; i < 256; i++) begin
            pc_in = 8'($urandom);
            tick();
        end

        // Bad high byte
        do_start();
        xfer(8'h22, 1'b0, 0);
        xfer(8'hC1, 1'b0, 0);
        chk("bad_err",   32'(ld_err),    32'h1);
        chk("bad_hold",  32'(core_hold), 32'h1);
        chk("bad_ready", 32'(ld_ready),  32'h0);
        chk("bad_inst",  32'(inst_out),  32'h0);
        do_start();
        chk("restart_err",   32'(ld_err),   32'h0);
        chk("restart_ready", 32'(ld_ready), 32'h1);

        // ld_start together with a byte in LOAD_HI
        do_start();
        load_word(8'h11, 8'h22, 1'b0, 0);
        xfer(8'h33, 1'b0, 0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h04; ld_last = 1'b1;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("abort_count", 32'(ld_count),  32'h0);
        chk("abort_hold",  32'(core_hold), 32'h1);
        load_word(8'h77, 8'h2A, 1'b1, 0);
        pc_in = 8'd0;
        #1;
        chk("abort_reload", 32'(inst_out), 32'h2A77);
        chk("abort_cnt1",   32'(ld_count), 32'h1);

        // Asynchronous reset while running
        pc_in = 8'd1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_hold",  32'(core_hold), 32'h1);
        chk("arst_inst",  32'(inst_out),  32'h0);
        chk("arst_count", 32'(ld_count),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("idle_hold", 32'(core_hold), 32'h1);
        do_start();
        load_word(8'h9A, 8'h15, 1'b1, 0);
        pc_in = 8'd0;
        #1;
        chk("rst_reload", 32'(inst_out), 32'h159A);
        pc_in = 8'd1;
        #1;
        chk("retained1", 32'(inst_out), 32'(tw[1]));
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/carbon_prog_loader.md
Name: carbon_prog_loader

Overview:
- Instruction-side responder for the carbon core: it owns the 14-bit instruction memory and answers the core's 8-bit program-counter fetch with the stored instruction word.
- A host streams a program in as a byte-wide valid/ready stream while the block holds the core in reset. The block then releases the core and serves fetches.
- Sits between the host/debug link and the core's PC_O/INST pins.

Parameters:
- AW, 8, address width; must match the core PC width.
- DEPTH, 256, number of instruction words (2**AW).
- IW, 14, instruction width: 6-bit opcode + 8-bit constant.

Ports:
- clk  in  1  single clock for everything.
- rst  in  1  asynchronous, active-low reset.
- ld_start  in  1  pulse; begins or restarts a program load.
- ld_valid  in  1  host byte valid.
- ld_ready  out  1  block can accept a byte.
- ld_byte  in  8  program byte: low byte (constant) first, then high byte (opcode in [5:0]).
- ld_last  in  1  qualifies a high byte as the final instruction.
- pc_in  in  AW  fetch address from the core.
- inst_out  out  IW  instruction for pc_in.
- core_hold  out  1  1 = hold the core in reset.
- ld_err  out  1  sticky load error.
- ld_count  out  AW+1  number of instructions written by the last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, core_hold=1, ld_ready=0, ld_err=0, ld_count=0, address counter=0, low-byte holding register=0.
  - Memory contents are not cleared.
- States: IDLE, LOAD_LO, LOAD_HI, RUN, ERR.
- ld_start has priority over every other event in every state:
  - Next state is LOAD_LO, addr=0, ld_count=0, ld_err=0, core_hold=1.
  - A byte presented in the same cycle is not accepted.
- Byte transfer happens on a cycle with ld_valid & ld_ready. ld_ready=1 only in LOAD_LO and LOAD_HI; it is combinational from state.
- LOAD_LO: on transfer, latch the byte into the holding register and go to LOAD_HI. ld_last is ignored on low bytes.
- LOAD_HI: on transfer:
  - If ld_byte[7:6] != 0: go to ERR, ld_err=1, no memory write.
  - Otherwise write mem[addr] = {ld_byte[5:0], lo} and increment addr and ld_count.
  - If ld_last=1: go to RUN. core_hold deasserts on the cycle after the transition, so the core leaves reset with the memory write already complete.
  - If ld_last=0 and addr==DEPTH-1: overflow. The write still occurs, ld_count=DEPTH, then go to ERR with ld_err=1.
  - Otherwise go to LOAD_LO.
- No transfer means hold state; ld_valid may idle indefinitely.
- RUN: core_hold=0. inst_out = mem[pc_in], a combinational read with zero latency, because the core samples INST within the same clkA phase.
- inst_out = 0 in every state other than RUN (opcode 0 is treated as a NOP).
- ERR: core_hold=1 and ld_ready=0. Only ld_start or reset exits.
- IDLE: core_hold=1; waits for ld_start.
- Reset asserted mid-load abandons the load immediately. Partially written words remain in memory but are never served until a full load completes.
- ld_count width is AW+1 so that the value DEPTH is representable.
- The address counter wraps only via restart; it never silently wraps to 0.

Decomposition:
- Shared package (carbon_pkg):
  - AW/IW constants.
  - Opcode field positions (OP = [13:8], C = [7:0]).
  - Loader state enum.
  - NOP encoding (14'h0000).
- One natural sub-module, carbon_imem: DEPTH x IW memory with a synchronous write port and an asynchronous read port. The FSM, counters and handshake stay in the top module.

Test Plan:
- Reset, then ld_start, then bytes 8'h05/8'h01 with ld_last=1 -> mem[0]=14'h0105, ld_count=1, core_hold falls one cycle after the final transfer; pc_in=0 gives inst_out=14'h0105.
- Three-instruction load with ld_valid gapped every other cycle -> ld_ready stays 1 throughout, ld_count=3, fetches at pc_in=0,1,2 return the loaded words, pc_in=3 returns the old memory contents.
- High byte 8'hC1 -> ld_err=1, state=ERR, core_hold=1, ld_ready=0, inst_out=0; a following ld_start clears ld_err and returns to LOAD_LO.
- 256 instructions with ld_last=0 throughout -> all 256 words written, ld_count=256, ld_err=1 after the last word, no write to address 0 from wrap-around.
- ld_start asserted together with ld_valid in LOAD_HI after one completed word -> byte rejected, addr=0, ld_count=0; the next load overwrites mem[0].
- rst pulsed low while in RUN mid-fetch -> core_hold=1 asynchronously, inst_out=0, state=IDLE; memory is retained, and a reload of 1 word serves it correctly.
